uart_frame_tx: RTL and testbench

Host-side command framer for the UART debug link. It accepts single 32-bit bus write or read-request commands on a valid/ack handshake, and serialises each as a fixed-format 8N1 byte frame on `tx_o`. It drives the SoC's UART receive pin (`rx_i`) from on-board test logic or a second FPGA, which makes it the initiator end of the link the SoC answers. Read responses travel back on the SoC's `tx_o` and are outside this block.

---
 rtl/uart_frame_pkg.sv | 39 +++
 rtl/uart_tx_byte.sv | 112 +++++++++++
 rtl/uart_frame_tx.sv | 147 ++++++++++++++
 tb/tb_uart_frame_tx.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: constants and state types shared by the UART command framer
// (uart_frame_tx) and its byte shifter (uart_tx_byte).
//   SYNC_BYTE / CMD_WR / CMD_RD : fixed frame header bytes
//   frame_state_t               : framer FSM states
//   shift_state_t               : byte shifter FSM states
//   word_byte()                 : picks byte 0..3 of a 32-bit word, [7:0] = byte 0
package uart_frame_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'h55;
    localparam logic [7:0] CMD_WR    = 8'hA5;
    localparam logic [7:0] CMD_RD    = 8'h5A;

    typedef enum logic [2:0] {
        FR_IDLE,
        FR_SYNC,
        FR_CMD,
        FR_ADDR,
        FR_DATA
    } frame_state_t;

    typedef enum logic [1:0] {
        SH_IDLE,
        SH_START,
        SH_BITS,
        SH_STOP
    } shift_state_t;

    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte shifter.
//   clk_i, arst_i : clock, asynchronous active-high reset
//   start_i       : load data_i and begin a byte (honoured in IDLE and in the
//                   last cycle of STOP, so bytes can run back to back)
//   data_i[7:0]   : byte to send, LSB first
//   tx_o          : registered serial output, idles high
//   done_o        : one-cycle pulse during the final cycle of the stop bit
module uart_tx_byte
    import uart_frame_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk_i,
    input  logic       arst_i,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       done_o
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    if (BAUD_DIV < 2) begin : g_div_check
        $error("uart_tx_byte: BAUD_DIV must be at least 2");
    end

    shift_state_t  state, state_next;
    logic [CW-1:0] baud_cnt, baud_next;
    logic [2:0]    bit_cnt, bit_next, bit_plus1;
    logic [7:0]    data_q;
    logic          tx_q, tx_next;
    logic          load;
    logic          bit_end;

    assign bit_end   = (baud_cnt == LAST);
    assign bit_plus1 = bit_cnt + 3'd1;
    assign tx_o      = tx_q;

    always_comb begin
        state_next = state;
        baud_next  = (state == SH_IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
        bit_next   = bit_cnt;
        tx_next    = tx_q;
        load       = 1'b0;
        done_o     = 1'b0;
        case (state)
            SH_IDLE: begin
                if (start_i) begin
                    state_next = SH_START;
                    tx_next    = 1'b0;
                    load       = 1'b1;
                end
            end
            SH_START: begin
                if (bit_end) begin
                    state_next = SH_BITS;
                    bit_next   = 3'd0;
                    tx_next    = data_q[0];
                end
            end
            SH_BITS: begin
                if (bit_end) begin
                    if (bit_cnt == 3'd7) begin
                        state_next = SH_STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_next = bit_plus1;
                        tx_next  = data_q[bit_plus1];
                    end
                end
            end
            SH_STOP: begin
                if (bit_end) begin
                    done_o = 1'b1;
                    // A start in the last stop cycle chains straight into the next start bit.
                    if (start_i) begin
                        state_next = SH_START;
                        tx_next    = 1'b0;
                        load       = 1'b1;
                    end else begin
                        state_next = SH_IDLE;
                        tx_next    = 1'b1;
                    end
                end
            end
            default: begin
                state_next = SH_IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state    <= SH_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            data_q   <= 8'h00;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_cnt  <= bit_next;
            tx_q     <= tx_next;
            if (load) begin
                data_q <= data_i;
            end
        end
    end

endmodule

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: serialises one bus command per request as an 8N1 frame:
//   55, A5/5A, ADDR[7:0..31:24], DATA[7:0..31:24] (write only).
//   clk_i, arst_i : clock, asynchronous active-high reset
//   req_i         : command request, held until ack_o is seen
//   we_i          : 1 = write, 0 = read-request
//   addr_i        : bus address
//   wdata_i       : write data (unused for read-request)
//   ack_o         : registered one-cycle pulse after the accept edge
//   busy_o        : frame in progress, high through the final stop bit
//   tx_o          : serial line, idles high
// Handshake: a command is taken on any clock edge where req_i=1 and busy_o=0;
// fields are latched on that edge and later input changes are ignored.
module uart_frame_tx
    import uart_frame_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BAUD_RATE   = 115200,
    parameter int BAUD_DIV    = CLK_FREQ_HZ / BAUD_RATE
) (
    input  logic        clk_i,
    input  logic        arst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ack_o,
    output logic        busy_o,
    output logic        tx_o
);

    if (BAUD_DIV < 2) begin : g_div_check
        $error("uart_frame_tx: BAUD_DIV must be at least 2");
    end

    frame_state_t state, state_next;
    logic [1:0]   byte_idx, idx_next;
    logic         we_q;
    logic [31:0]  addr_q;
    logic [31:0]  wdata_q;
    logic         ack_q;
    logic         accept;
    logic         byte_start;
    logic [7:0]   byte_data;
    logic         byte_done;

    assign busy_o = (state != FR_IDLE);
    assign accept = req_i && (state == FR_IDLE);
    assign ack_o  = ack_q;

    // Each state loads the following byte in the same cycle the shifter
    // reports done, so there is no idle time between bytes of a frame.
    always_comb begin
        state_next = state;
        idx_next   = byte_idx;
        byte_start = 1'b0;
        byte_data  = SYNC_BYTE;
        case (state)
            FR_IDLE: begin
                if (accept) begin
                    state_next = FR_SYNC;
                    byte_start = 1'b1;
                    byte_data  = SYNC_BYTE;
                end
            end
            FR_SYNC: begin
                if (byte_done) begin
                    state_next = FR_CMD;
                    byte_start = 1'b1;
                    byte_data  = we_q ? CMD_WR : CMD_RD;
                end
            end
            FR_CMD: begin
                if (byte_done) begin
                    state_next = FR_ADDR;
                    idx_next   = 2'd0;
                    byte_start = 1'b1;
                    byte_data  = word_byte(addr_q, 2'd0);
                end
            end
            FR_ADDR: begin
                if (byte_done) begin
                    if (byte_idx != 2'd3) begin
                        idx_next   = byte_idx + 2'd1;
                        byte_start = 1'b1;
                        byte_data  = word_byte(addr_q, byte_idx + 2'd1);
                    end else if (we_q) begin
                        state_next = FR_DATA;
                        idx_next   = 2'd0;
                        byte_start = 1'b1;
                        byte_data  = word_byte(wdata_q, 2'd0);
                    end else begin
                        state_next = FR_IDLE;
                        idx_next   = 2'd0;
                    end
                end
            end
            FR_DATA: begin
                if (byte_done) begin
                    if (byte_idx != 2'd3) begin
                        idx_next   = byte_idx + 2'd1;
                        byte_start = 1'b1;
                        byte_data  = word_byte(wdata_q, byte_idx + 2'd1);
                    end else begin
                        state_next = FR_IDLE;
                        idx_next   = 2'd0;
                    end
                end
            end
            default: begin
                state_next = FR_IDLE;
                idx_next   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state    <= FR_IDLE;
            byte_idx <= 2'd0;
            we_q     <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            ack_q    <= 1'b0;
        end else begin
            state    <= state_next;
            byte_idx <= idx_next;
            ack_q    <= accept;
            if (accept) begin
                we_q    <= we_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
            end
        end
    end

    uart_tx_byte #(
        .BAUD_DIV(BAUD_DIV)
    ) u_byte (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .start_i(byte_start),
        .data_i (byte_data),
        .tx_o   (tx_o),
        .done_o (byte_done)
    );

endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx: bench for uart_frame_tx with BAUD_DIV = 10.
// A negedge line decoder rebuilds bytes from tx and compares them against the
// expected-byte queue filled when each command is driven.
module tb_uart_frame_tx;

  localparam int CLK_FREQ_HZ = 1000000;
  localparam int BAUD_RATE   = 100000;
  localparam int BAUD_DIV    = 10;
  localparam int SAMPLE_OFS  = BAUD_DIV / 2 - 1;
  localparam int WR_CYCLES   = 100 * BAUD_DIV;
  localparam int RD_CYCLES   = 60 * BAUD_DIV;

  logic        clk = 1'b0;
  logic        arst = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        ack;
  logic        busy;
  logic        tx;

  uart_frame_tx #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .BAUD_RATE  (BAUD_RATE)
  ) dut (
    .clk_i  (clk),
    .arst_i (arst),
    .req_i  (req),
    .we_i   (we),
    .addr_i (addr),
    .wdata_i(wdata),
    .ack_o  (ack),
    .busy_o (busy),
    .tx_o   (tx)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int total = 0;
  int bad = 0;

  int ack_cnt = 0;
  int busy_run = 0;
  int busy_len = 0;
  int busy_total = 0;
  int tx_edges = 0;
  logic tx_prev = 1'b1;

  logic       mon_act = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_frame(input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back(8'h55);
    exp_q.push_back(w ? 8'hA5 : 8'h5A);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'((a >> (8 * i)) & 32'hFF));
    if (w) begin
      for (int i = 0; i < 4; i++) exp_q.push_back(8'((d >> (8 * i)) & 32'hFF));
    end
  endfunction

  // ---------------- line decoder / activity monitor ----------------
  always @(negedge clk) begin
    if (tx !== tx_prev) tx_edges++;
    tx_prev = tx;
    if (arst) begin
      mon_act  = 1'b0;
      mon_cnt  = 0;
      busy_run = 0;
    end else begin
      if (ack) ack_cnt++;
      if (busy) begin
        busy_run++;
        busy_total++;
      end else if (busy_run != 0) begin
        busy_len = busy_run;
        busy_run = 0;
      end
      if (!mon_act) begin
        if (tx == 1'b0) begin
          mon_act = 1'b1;
          mon_cnt = 0;
        end
      end else begin
        mon_cnt++;
        if (mon_cnt >= SAMPLE_OFS && (mon_cnt - SAMPLE_OFS) % BAUD_DIV == 0) begin
          int k;
          k = (mon_cnt - SAMPLE_OFS) / BAUD_DIV;
          if (k == 0) begin
            check("start_bit", {31'h0, tx}, 32'h0);
          end else if (k <= 8) begin
            mon_byte[k-1] = tx;
          end else begin
            check("stop_bit", {31'h0, tx}, 32'h1);
            total++;
            if (exp_q.size() == 0) begin
              bad++;
              $display("FAIL rx_byte: got %02h want none (unexpected byte) at t=%0t", mon_byte, $time);
            end else begin
              logic [7:0] e;
              e = exp_q.pop_front();
              if (mon_byte !== e) begin
                bad++;
                $display("FAIL rx_byte: got %02h want %02h at t=%0t", mon_byte, e, $time);
              end
            end
            mon_act = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic got;
    got = 1'b0;
    @(negedge clk);
    req = 1'b1;
    we = w;
    addr = a;
    wdata = d;
    push_frame(w, a, d);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (ack) begin
        got = 1'b1;
        break;
      end
    end
    req = 1'b0;
    check("ack_seen", {31'h0, got}, 32'h1);
  endtask

  task automatic wait_idle(input logic scramble);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      @(posedge clk);
      #1;
      if (scramble) begin
        we = 1'($urandom_range(0, 1));
        addr = $urandom;
        wdata = $urandom;
      end
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    check("idle_reached", {31'h0, done}, 32'h1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          busy_cycles;
  } vec_t;

  vec_t vecs[4];

  // ---------------- watchdog ----------------
  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want completion");
    bad++;
    total++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int ack_base;
    int edge_base;
    int busy_base;
    int t0;
    int t1;
    int t2;
    logic got2;
    logic prev_busy;
    logic prev_tx;

    vecs[0] = '{we: 1'b1, addr: 32'h10000004, wdata: 32'hDEADBEEF, busy_cycles: WR_CYCLES};
    vecs[1] = '{we: 1'b0, addr: 32'h00000100, wdata: 32'h12345678, busy_cycles: RD_CYCLES};
    vecs[2] = '{we: 1'b1, addr: $urandom, wdata: $urandom, busy_cycles: WR_CYCLES};
    vecs[3] = '{we: 1'b0, addr: $urandom, wdata: $urandom, busy_cycles: RD_CYCLES};

    // Reset: 3 cycles, then 50 quiet cycles.
    #2 arst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", {31'h0, tx}, 32'h1);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_ack", {31'h0, ack}, 32'h0);
    arst = 1'b0;
    edge_base = tx_edges;
    busy_base = busy_total;
    repeat (50) @(posedge clk);
    #1;
    check("quiet_tx_edges", 32'(tx_edges - edge_base), 32'h0);
    check("quiet_busy", 32'(busy_total - busy_base), 32'h0);
    check("quiet_ack", 32'(ack_cnt), 32'h0);

    // Table-driven single commands; inputs scrambled while each frame runs.
    for (int v = 0; v < 4; v++) begin
      ack_base = ack_cnt;
      send_cmd(vecs[v].we, vecs[v].addr, vecs[v].wdata);
      wait_idle(1'b1);
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("vec%0d_acks", v), 32'(ack_cnt - ack_base), 32'h1);
      check($sformatf("vec%0d_busy_len", v), 32'(busy_len), 32'(vecs[v].busy_cycles));
      check($sformatf("vec%0d_drained", v), 32'(exp_q.size()), 32'h0);
    end

    // Back-to-back writes with req held high.
    ack_base = ack_cnt;
    @(negedge clk);
    req = 1'b1;
    we = 1'b1;
    addr = 32'hA0A0_0001;
    wdata = 32'h0F0F_1234;
    push_frame(1'b1, 32'hA0A0_0001, 32'h0F0F_1234);
    got2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (ack) begin
        got2 = 1'b1;
        break;
      end
    end
    check("b2b_ack1", {31'h0, got2}, 32'h1);
    t0 = cyc;
    addr = 32'h5555_AAAA;
    wdata = 32'h8000_0001;
    push_frame(1'b1, 32'h5555_AAAA, 32'h8000_0001);
    got2 = 1'b0;
    prev_busy = busy;
    prev_tx = tx;
    for (int i = 0; i < 1100; i++) begin
      @(posedge clk);
      #1;
      if (ack) begin
        got2 = 1'b1;
        break;
      end
      prev_busy = busy;
      prev_tx = tx;
    end
    req = 1'b0;
    t1 = cyc;
    check("b2b_ack2", {31'h0, got2}, 32'h1);
    check("b2b_ack_gap", 32'(t1 - t0), 32'(WR_CYCLES + 1));
    check("b2b_gap_busy", {31'h0, prev_busy}, 32'h0);
    check("b2b_gap_tx", {31'h0, prev_tx}, 32'h1);
    wait_idle(1'b0);
    t2 = cyc;
    check("b2b_total", 32'(t2 - t0), 32'(2 * WR_CYCLES + 1));
    repeat (2) @(posedge clk);
    #1;
    check("b2b_acks", 32'(ack_cnt - ack_base), 32'h2);
    check("b2b_drained", 32'(exp_q.size()), 32'h0);

    // Reset during ADDR byte 2, data bit 4 (addr byte 2 = 0x00, so the line is low).
    send_cmd(1'b1, 32'h1200_5678, 32'hCAFE_F00D);
    repeat (455) @(posedge clk);
    #3;
    check("mid_rst_line_low", {31'h0, tx}, 32'h0);
    arst = 1'b1;
    #1;
    check("mid_rst_tx", {31'h0, tx}, 32'h1);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_ack", {31'h0, ack}, 32'h0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    arst = 1'b0;
    repeat (3) @(posedge clk);
    ack_base = ack_cnt;
    send_cmd(1'b1, 32'h0000_0042, 32'h7654_3210);
    wait_idle(1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_acks", 32'(ack_cnt - ack_base), 32'h1);
    check("post_rst_busy_len", 32'(busy_len), 32'(WR_CYCLES));
    check("post_rst_drained", 32'(exp_q.size()), 32'h0);

    // Request pulsed while busy: ignored, no second frame.
    ack_base = ack_cnt;
    busy_base = busy_total;
    send_cmd(1'b0, 32'h0000_ABCD, 32'h0);
    repeat (100) @(posedge clk);
    #1;
    req = 1'b1;
    we = 1'b1;
    addr = 32'hFFFF_0000;
    wdata = 32'h1111_2222;
    repeat (5) @(posedge clk);
    #1;
    req = 1'b0;
    wait_idle(1'b0);
    repeat (200) @(posedge clk);
    #1;
    check("busy_req_acks", 32'(ack_cnt - ack_base), 32'h1);
    check("busy_req_busy_len", 32'(busy_len), 32'(RD_CYCLES));
    check("busy_req_busy_total", 32'(busy_total - busy_base), 32'(RD_CYCLES));
    check("busy_req_drained", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
